// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_wr_arbiter                                              |
// | Purpose  : Shares the register-file write port between the pipeline (A)    |
// |            and a buffered multi-cycle unit (B) with an anti-starvation      |
// |            stall, and tracks registers with outstanding B results.          |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [63:0] a_data,
    output logic        stall_a,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [63:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    output logic [31:0] pending,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [4:0]         c_XZR   = 5'd31;

    logic [4:0]         r_fifo_reg  [DEPTH];
    logic [63:0]        r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [3:0]         r_wait_cnt;
    logic               r_stall_a;
    logic [31:0]        r_pending;
    logic               r_reg_write;
    logic [4:0]         r_wr_reg;
    logic [63:0]        r_wr_data;

    logic               w_empty;
    logic               w_push;
    logic               w_grant_a;
    logic               w_grant_b;
    logic [4:0]         w_head_reg;
    logic [63:0]        w_head_data;
    logic [3:0]         w_wait_next;
    logic [31:0]        w_pending_next;
    logic [c_CNT_W-1:0] w_count_next;

    assign w_empty     = (r_count == '0);
    assign b_ready     = (r_count != c_DEPTH);
    assign w_push      = b_valid && b_ready;
    assign w_head_reg  = r_fifo_reg[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // A stall forces the buffered head through; otherwise A has priority.
    assign w_grant_b = !w_empty && (r_stall_a || !a_valid);
    assign w_grant_a = a_valid && !w_grant_b;

    assign w_count_next = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_grant_b};

    always_comb begin
        w_wait_next = 4'd0;
        if (!w_empty && !w_grant_b) begin
            w_wait_next = (r_wait_cnt >= c_LIMIT) ? c_LIMIT : r_wait_cnt + 4'd1;
        end
    end

    // Clear before set so a same-cycle reissue keeps the bit outstanding.
    always_comb begin
        w_pending_next = r_pending;
        if (w_grant_b) begin
            w_pending_next[w_head_reg] = 1'b0;
        end
        if (issue_valid && (issue_reg != c_XZR)) begin
            w_pending_next[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= b_reg;
            r_fifo_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_wait_cnt <= 4'd0;
            r_stall_a  <= 1'b0;
            r_pending  <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_grant_b) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_wait_cnt <= w_wait_next;
            r_stall_a  <= (w_wait_next >= c_LIMIT);
            r_pending  <= w_pending_next;
        end
    end

    // Writes to X31 are consumed but leave index/data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write <= 1'b0;
            r_wr_reg    <= 5'd0;
            r_wr_data   <= 64'd0;
        end else begin
            r_reg_write <= 1'b0;
            if (w_grant_a && (a_reg != c_XZR)) begin
                r_reg_write <= 1'b1;
                r_wr_reg    <= a_reg;
                r_wr_data   <= a_data;
            end else if (w_grant_b && (w_head_reg != c_XZR)) begin
                r_reg_write <= 1'b1;
                r_wr_reg    <= w_head_reg;
                r_wr_data   <= w_head_data;
            end
        end
    end

    assign stall_a       = r_stall_a;
    assign pending       = r_pending;
    assign RegWrite      = r_reg_write;
    assign WriteRegister = r_wr_reg;
    assign WriteData     = r_wr_data;

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and long-latency scoreboard for the 32×64 register file (X31 hardwired zero, writes taken on the falling clock edge). It shares the single write port between the in-order pipeline writeback (requester A) and a multi-cycle execution unit (requester B, e.g. multiplier/divider). It buffers B results in a small FIFO and prevents B from starving behind continuous A writes. It also tracks which registers still have a B result outstanding, so decode can stall on them.

## Interface
- STARVE_LIMIT, 3: consecutive cycles a buffered B result may wait before A is stalled (1..15).
- DEPTH, 2: B result FIFO entries (power of two, ≥2).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- a_valid  in  1  pipeline writeback request this cycle.
- a_reg  in  5  A destination register.
- a_data  in  64  A write data.
- stall_a  out  1  registered; when 1, A is not written this cycle and the pipeline must hold a_valid/a_reg/a_data unchanged.
- b_valid  in  1  B result available.
- b_ready  out  1  FIFO not full; push occurs when b_valid && b_ready.
- b_reg  in  5  B destination register.
- b_data  in  64  B result data.
- issue_valid  in  1  a long-latency op is issued to B this cycle.
- issue_reg  in  5  its destination register.
- pending  out  32  bit r = 1 while a B result for register r is outstanding; bit 31 always 0.
- RegWrite  out  1  register file write enable (registered).
- WriteRegister  out  5  register file write index (registered).
- WriteData  out  64  register file write data (registered).

## Operation
- Grant, evaluated each cycle:
  - If stall_a = 1 and the FIFO is non-empty, B head is granted.
  - Otherwise, if a_valid = 1, A is granted.
  - Otherwise, if the FIFO is non-empty, B head is granted.
  - Otherwise, nothing is granted.
- A B grant pops the FIFO head in the same cycle.
- Granted request is registered onto RegWrite/WriteRegister/WriteData next cycle.
- Granted target = 31: the request is consumed (A accepted or B popped), but RegWrite = 0 for that slot and WriteRegister/WriteData hold their previous values.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle are both honored, count unchanged.
  - A push into an empty FIFO is not visible for grant until the next cycle (no bypass).
- Starvation counter (wait_cnt):
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop, and while the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_a next = (wait_cnt_next ≥ STARVE_LIMIT).
  - Asserts for exactly one cycle per starvation event, because that cycle's forced grant pops B and clears the counter.
- Scoreboard:
  - issue_valid with issue_reg ≠ 31 sets pending[issue_reg].
  - A B grant (pop) clears pending[head reg].
  - Set and clear of the same bit in the same cycle: the set wins (new issue outstanding).
  - A grants never touch pending.
- Ordering contract: decode does not issue an A-producing instruction to a register whose pending bit is set. The arbiter performs no same-register ordering check between A and B.
- B results leave in push order (FIFO). B need not return results in issue order, but each result clears only its own register's bit.

## Timing
- Reset (async, rst_n = 0), all regardless of clock:
  - RegWrite = 0, WriteRegister = 0, WriteData = 0.
  - stall_a = 0, b_ready = 1, pending = 0.
  - FIFO empty, wait_cnt = 0.
- Reset asserted mid-operation discards buffered B results and pending bits; the first grant is possible in the first rising edge after release.
- Latency:
  - A request → RegWrite at the next rising edge (1 cycle).
  - B push → earliest RegWrite 2 cycles later (push edge, then grant edge).
- b_ready is combinational from count only: it is low exactly when count = DEPTH, and does not look ahead to a same-cycle pop.
- Worst-case B wait with continuous a_valid: STARVE_LIMIT + 1 cycles from becoming FIFO head to grant.

## Test plan
- Reset: drive rst_n = 0 mid-traffic, with no clock edge → all outputs at reset values immediately; b_ready = 1, pending = 0.
- A only: a_valid = 1, a_reg = 5, a_data = 0x1234 for 1 cycle → next cycle RegWrite = 1, WriteRegister = 5, WriteData = 0x1234; stall_a stays 0.
- B only with scoreboard:
  - issue_valid, issue_reg = 7 → pending[7] = 1.
  - Later push b_reg = 7, b_data = 0xAB → RegWrite with reg 7 two cycles after the push; pending[7] clears on the grant edge.
- Starvation (STARVE_LIMIT = 3): a_valid held high continuously, then one B result pushed → stall_a = 1 for exactly one cycle, 3 cycles after the push becomes visible. In that cycle's write, WriteRegister = B reg; the held A request is written the following cycle.
- Full / XZR:
  - Push 3 B results while a_valid is held high → b_ready = 0 after the 2nd push; the 3rd is accepted only after a pop.
  - A write to reg 31 → consumed with RegWrite = 0.
- Same-cycle set/clear: issue_reg = 9 in the same cycle B pops a reg-9 result → pending[9] remains 1.
